// File: rtl/ex_operand_stage.sv
// ID/EX stage register with forwarding-select operand muxing and load-use bubble insertion.
// Optional load-use stall counter enabled by defining EX_OPERAND_STALL_CNT_EN.
module ex_operand_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [1:0]        forward_a,
   input  logic [1:0]        forward_b,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_op_a,
   output logic [XLEN-1:0]   ex_op_b,
   output logic [4:0]        ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       stall_cnt
);

   localparam int unsigned CNT_W = 32;

   logic              advance;
   logic              hazard;
   logic              capture;
   logic              bubble;
   logic              rs1_hit;
   logic              rs2_hit;
   logic              reg_write_q;
   logic [XLEN-1:0]   op_a_sel;
   logic [XLEN-1:0]   op_b_sel;

   // Hazard detection and handshake decisions on current-cycle inputs.
   always_comb begin
      advance  = 1'b0;
      hazard   = 1'b0;
      rs1_hit  = 1'b0;
      rs2_hit  = 1'b0;
      capture  = 1'b0;
      bubble   = 1'b0;
      id_ready = 1'b0;

      advance  = !ex_valid || ex_ready;
      rs1_hit  = id_use_rs1 && (ex_rd == id_rs1);
      rs2_hit  = id_use_rs2 && (ex_rd == id_rs2);
      hazard   = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
      id_ready = flush || (advance && !hazard);
      capture  = !flush && advance && id_valid && !hazard;
      bubble   = !flush && advance && !capture;
   end

   // Bypass muxes; select 11 falls back to the register file.
   always_comb begin
      op_a_sel = id_rs1_data;
      op_b_sel = id_rs2_data;
      case (forward_a)
         2'b10:   op_a_sel = ex_result;
         2'b01:   op_a_sel = mem_result;
         default: op_a_sel = id_rs1_data;
      endcase
      case (forward_b)
         2'b10:   op_b_sel = ex_result;
         2'b01:   op_b_sel = mem_result;
         default: op_b_sel = id_rs2_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
      end else if (flush || bubble) begin
         ex_valid <= 1'b0;
      end else if (capture) begin
         ex_valid <= 1'b1;
      end
   end

   // Payload registers load only on capture, so they hold through bubbles and back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_pc       <= '0;
         ex_imm      <= '0;
         ex_op_a     <= '0;
         ex_op_b     <= '0;
         ex_rd       <= '0;
         reg_write_q <= 1'b0;
         ex_mem_read <= 1'b0;
         ex_ctrl     <= '0;
      end else if (capture) begin
         ex_pc       <= id_pc;
         ex_imm      <= id_imm;
         ex_op_a     <= op_a_sel;
         ex_op_b     <= op_b_sel;
         ex_rd       <= id_rd;
         reg_write_q <= id_reg_write;
         ex_mem_read <= id_mem_read;
         ex_ctrl     <= id_ctrl;
      end
   end

   assign ex_reg_write = ex_valid && reg_write_q;

`ifdef EX_OPERAND_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;

   // Saturating count of cycles an ID instruction is held by a load-use hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (id_valid && hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = CNT_W'(0);
`endif

endmodule
